// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state, mode types and constants for the parametrised SPI master
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FRONT,
      SHIFT,
      BACK
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam int MIN_HALF_DIV = 2;

   // Slave-select index width; a single slave still gets a 1-bit select.
   function automatic int ss_width(input int num_ss);
      return (num_ss > 1) ? $clog2(num_ss) : 1;
   endfunction

endpackage

// File: rtl/spi_mstr_param_if.sv
// rtl/spi_mstr_param_if.sv - host control and SPI bus signals of the parametrised SPI master
interface spi_mstr_param_if #(
   parameter int DATA_W = 16,
   parameter int NUM_SS = 2,
   parameter int SS_W   = spi_pkg::ss_width(NUM_SS)
);
   logic                      wrt;
   logic [DATA_W-1:0]         cmd;
   logic [$clog2(DATA_W)-1:0] len;
   logic                      cpol;
   logic                      cpha;
   logic [SS_W-1:0]           ss_sel;
   logic                      done;
   logic [DATA_W-1:0]         rd_data;
   logic [NUM_SS-1:0]         SS_n;
   logic                      SCLK;
   logic                      MOSI;
   logic                      MISO;

   modport master (
      input  wrt, cmd, len, cpol, cpha, ss_sel, MISO,
      output done, rd_data, SS_n, SCLK, MOSI
   );

   modport slave (
      output wrt, cmd, len, cpol, cpha, ss_sel, MISO,
      input  done, rd_data, SS_n, SCLK, MOSI
   );
endinterface

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - half-period counter, SCLK toggle and one-cycle lead/trail edge strobes
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int HALF_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_toggle,
   input  logic i_cpol,
   output logic o_sclk,
   output logic o_tick,
   output logic o_lead_edge,
   output logic o_trail_edge
);
   localparam int HD    = (HALF_DIV < MIN_HALF_DIV) ? MIN_HALF_DIV : HALF_DIV;
   localparam int CNT_W = $clog2(HD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_sclk;
   logic             r_lead;
   logic             r_trail;
   logic             w_term;
   logic             w_flip;

   assign w_term = i_en && (r_cnt == CNT_LAST);
   assign w_flip = w_term && i_toggle;

   // Clear parks SCLK at the idle level of the upcoming or finished transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_sclk  <= 1'b0;
         r_lead  <= 1'b0;
         r_trail <= 1'b0;
      end else if (i_clr) begin
         r_cnt   <= '0;
         r_sclk  <= i_cpol;
         r_lead  <= 1'b0;
         r_trail <= 1'b0;
      end else begin
         r_lead  <= w_flip && (r_sclk == i_cpol);
         r_trail <= w_flip && (r_sclk != i_cpol);
         if (w_flip) begin
            r_sclk <= ~r_sclk;
         end
         if (w_term) begin
            r_cnt <= '0;
         end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_sclk       = r_sclk;
   assign o_tick       = w_term;
   assign o_lead_edge  = r_lead;
   assign o_trail_edge = r_trail;

endmodule

// File: rtl/spi_mstr_param.sv
// rtl/spi_mstr_param.sv - run-time mode/length SPI master with porches and one-hot active-low selects
// Build option SPI_MOSI_TRISTATE_EN: MOSI floats whenever every SS_n is high.
module spi_mstr_param
   import spi_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int HALF_DIV = 16,
   parameter int NUM_SS   = 2,
   parameter int SS_W     = ss_width(NUM_SS)
) (
   input  logic               clk,
   input  logic               rst,
   spi_mstr_param_if.master   bus
);
   localparam int LEN_W = $clog2(DATA_W);
   localparam int BC_W  = LEN_W + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W - 1);

   spi_state_t        r_state;
   spi_state_t        w_next;
   spi_mode_t         r_mode;
   logic [LEN_W-1:0]  r_len;
   logic [SS_W-1:0]   r_sel;
   logic [DATA_W-1:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_rd_data;
   logic [BC_W-1:0]   r_bit_cnt;
   logic              r_done;
   logic              r_mosi;

   logic              w_accept;
   logic              w_sclk;
   logic              w_tick;
   logic              w_lead;
   logic              w_trail;
   logic              w_toggle;
   logic              w_sample;
   logic              w_advance;
   logic              w_last_bit;
   logic              w_gen_cpol;
   logic [BC_W-1:0]   w_nbits;
   logic [DATA_W-1:0] w_align;
   logic [NUM_SS-1:0] w_ss_n;

   // done is only ever high in IDLE, so it doubles as the accept qualifier.
   assign w_accept   = bus.wrt && r_done;
   assign w_nbits    = {1'b0, r_len} + BC_W'(1);
   assign w_last_bit = (r_bit_cnt == w_nbits);
   assign w_align    = bus.cmd << (LEN_MAX - bus.len);
   assign w_sample   = r_mode.cpha ? w_trail : w_lead;
   assign w_advance  = r_mode.cpha ? w_lead : w_trail;
   assign w_toggle   = (r_state == FRONT) || ((r_state == SHIFT) && !w_last_bit);
   assign w_gen_cpol = w_accept ? bus.cpol : r_mode.cpol;

   spi_sclk_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_sclk_gen (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (r_state == IDLE),
      .i_en         (r_state != IDLE),
      .i_toggle     (w_toggle),
      .i_cpol       (w_gen_cpol),
      .o_sclk       (w_sclk),
      .o_tick       (w_tick),
      .o_lead_edge  (w_lead),
      .o_trail_edge (w_trail)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next = FRONT;
         FRONT:   if (w_tick) w_next = SHIFT;
         SHIFT:   if (w_tick && w_last_bit) w_next = BACK;
         BACK:    if (w_tick) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // The cycle after BACK returns to IDLE publishes the result and releases the slave.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode    <= '0;
         r_len     <= '0;
         r_sel     <= '0;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rd_data <= '0;
         r_bit_cnt <= '0;
         r_done    <= 1'b1;
         r_mosi    <= 1'b0;
      end else if (w_accept) begin
         r_mode.cpol <= bus.cpol;
         r_mode.cpha <= bus.cpha;
         r_len       <= bus.len;
         r_sel       <= bus.ss_sel;
         r_rx        <= '0;
         r_bit_cnt   <= '0;
         r_done      <= 1'b0;
         r_mosi      <= bus.cpha ? 1'b0 : w_align[DATA_W-1];
         r_tx        <= bus.cpha ? w_align : (w_align << 1);
      end else if ((r_state == IDLE) && !r_done) begin
         r_done    <= 1'b1;
         r_rd_data <= r_rx;
         r_mosi    <= 1'b0;
      end else begin
         if (w_advance) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
         end
         if (w_sample) begin
            r_rx <= {r_rx[DATA_W-2:0], bus.MISO};
         end
         if (w_trail) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   // r_sel is stable for the whole transfer, so only r_done switches the decode.
   always_comb begin
      w_ss_n = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (!r_done && (r_sel == SS_W'(i))) begin
            w_ss_n[i] = 1'b0;
         end
      end
   end

   assign bus.SS_n    = w_ss_n;
   assign bus.SCLK    = w_sclk;
   assign bus.done    = r_done;
   assign bus.rd_data = r_rd_data;

`ifdef SPI_MOSI_TRISTATE_EN
   assign bus.MOSI = (&w_ss_n) ? 1'bz : r_mosi;
`else
   assign bus.MOSI = r_mosi;
`endif

endmodule

// File: tb/tb_spi_mstr_param.sv
// tb/tb_spi_mstr_param.sv - directed scoreboard bench for spi_mstr_param with a cycle-sampled slave model
module tb_spi_mstr_param;
   localparam int DW  = 16;
   localparam int HD  = 4;
   localparam int NSS = 2;

`ifdef SPI_MOSI_TRISTATE_EN
   localparam logic MOSI_IDLE = 1'bz;
`else
   localparam logic MOSI_IDLE = 1'b0;
`endif

   typedef struct {
      logic [15:0] rd;
      logic [15:0] mosi;
      int          edges;
      logic [1:0]  ss;
      int          lat;
      logic        cpol;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   spi_mstr_param_if #(.DATA_W(DW), .NUM_SS(NSS)) bus ();

   spi_mstr_param #(
      .DATA_W   (DW),
      .HALF_DIV (HD),
      .NUM_SS   (NSS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Slave model configuration, written by the stimulus.
   logic        s_cpol = 1'b0;
   logic        s_cpha = 1'b0;
   logic [3:0]  s_len  = 4'd0;
   logic [15:0] s_word = 16'h0;
   logic [1:0]  s_ss_exp = 2'b11;

   // Slave model observations.
   int          s_edges  = 0;
   int          s_ss_bad = 0;
   int          s_bit    = 0;
   bit          s_act    = 1'b0;
   logic [15:0] s_mosi   = 16'h0;
   logic        s_prev   = 1'b0;

   always @(negedge clk) begin
      if (bus.done !== 1'b0) begin
         s_act    = 1'b0;
         bus.MISO = 1'b0;
      end else if (!s_act) begin
         s_act    = 1'b1;
         s_edges  = 0;
         s_ss_bad = 0;
         s_mosi   = 16'h0;
         s_bit    = int'(s_len);
         bus.MISO = s_cpha ? 1'b0 : s_word[s_bit];
      end else begin
         if (bus.SS_n !== s_ss_exp) s_ss_bad++;
         if (bus.SCLK !== s_prev) begin
            s_edges++;
            if ((bus.SCLK != s_cpol) != s_cpha) begin
               s_mosi = {s_mosi[14:0], bus.MOSI};
            end else if (s_cpha) begin
               bus.MISO = (s_bit >= 0) ? s_word[s_bit] : 1'b0;
               s_bit--;
            end else begin
               s_bit--;
               bus.MISO = (s_bit >= 0) ? s_word[s_bit] : 1'b0;
            end
         end
      end
      s_prev = bus.SCLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic start_xfer(input logic [15:0] cmd, input logic [3:0] len, input logic cpol,
                             input logic cpha, input logic sel, input logic [15:0] word);
      @(negedge clk);
      s_cpol   = cpol;
      s_cpha   = cpha;
      s_len    = len;
      s_word   = word;
      s_ss_exp = sel ? 2'b01 : 2'b10;
      bus.cmd    = cmd;
      bus.len    = len;
      bus.cpol   = cpol;
      bus.cpha   = cpha;
      bus.ss_sel = sel;
      bus.wrt    = 1'b1;
      @(posedge clk);
      #1 bus.wrt = 1'b0;
   endtask

   task automatic run_xfer(input string tag, input logic [15:0] cmd, input logic [3:0] len,
                           input logic cpol, input logic cpha, input logic sel,
                           input logic [15:0] word, input bit collide);
      exp_t        e;
      int          c;
      logic [16:0] one;
      logic [15:0] mask;
      one     = 17'd1;
      mask    = 16'((one << ({1'b0, len} + 5'd1)) - 17'd1);
      e.rd    = word & mask;
      e.mosi  = cmd & mask;
      e.edges = 2 * (int'(len) + 1);
      e.ss    = sel ? 2'b01 : 2'b10;
      e.lat   = (2 * (int'(len) + 1) + 2) * HD + 1;
      e.cpol  = cpol;
      sb.push_back(e);
      start_xfer(cmd, len, cpol, cpha, sel, word);
      chk({tag, "_done_low"}, bus.done, 1'b0);
      chk({tag, "_mosi_driven"}, 32'(bus.MOSI !== 1'bz), 1);
      c = 0;
      while (c < 4000) begin
         @(posedge clk);
         #1 c++;
         if (bus.done === 1'b1) break;
         bus.wrt = collide && (c == 40 || c == e.lat - 1);
      end
      bus.wrt = 1'b0;
      e = sb.pop_front();
      chk({tag, "_latency"}, c, e.lat);
      chk({tag, "_rd_data"}, bus.rd_data, e.rd);
      chk({tag, "_mosi_bits"}, s_mosi, e.mosi);
      chk({tag, "_sclk_edges"}, s_edges, e.edges);
      chk({tag, "_ss_active_errs"}, s_ss_bad, 0);
      chk({tag, "_ss_idle"}, bus.SS_n, 2'b11);
      repeat (20) @(posedge clk);
      #1;
      chk({tag, "_done_hold"}, bus.done, 1'b1);
      chk({tag, "_sclk_idle"}, bus.SCLK, e.cpol);
      chk({tag, "_mosi_idle"}, bus.MOSI, MOSI_IDLE);
      chk({tag, "_rd_hold"}, bus.rd_data, e.rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      bus.wrt    = 1'b0;
      bus.cmd    = '0;
      bus.len    = '0;
      bus.cpol   = 1'b0;
      bus.cpha   = 1'b0;
      bus.ss_sel = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ss_n", bus.SS_n, 2'b11);
      chk("reset_sclk", bus.SCLK, 1'b0);
      chk("reset_done", bus.done, 1'b1);
      chk("reset_rd_data", bus.rd_data, 16'h0);
      chk("reset_mosi", bus.MOSI, MOSI_IDLE);
      @(negedge clk) rst = 1'b0;

      run_xfer("mode0", 16'hA5C3, 4'd15, 1'b0, 1'b0, 1'b0, 16'h3C5A, 1'b0);
      run_xfer("mode3", 16'h00F0, 4'd7,  1'b1, 1'b1, 1'b0, 16'h0081, 1'b0);
      run_xfer("mode1", 16'h9B27, 4'd11, 1'b0, 1'b1, 1'b1, 16'h0D4E, 1'b0);
      run_xfer("mode2", 16'h6E1D, 4'd9,  1'b1, 1'b0, 1'b1, 16'h02B7, 1'b0);
      run_xfer("collide", 16'h1234, 4'd15, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b1);
      run_xfer("len0", 16'hFFFF, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);

      // Abort a transfer around bit 5, then prove the block recovers.
      start_xfer(16'hC3A5, 4'd15, 1'b1, 1'b0, 1'b1, 16'hFFFF);
      c = 0;
      while ((c < 2 || s_edges < 10) && c < 2000) begin
         @(posedge clk);
         #1 c++;
      end
      chk("rst_mid_reached", 32'(c < 2000), 1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_ss_n", bus.SS_n, 2'b11);
      chk("rst_mid_sclk", bus.SCLK, 1'b0);
      chk("rst_mid_done", bus.done, 1'b1);
      chk("rst_mid_rd_data", bus.rd_data, 16'h0);
      chk("rst_mid_mosi", bus.MOSI, MOSI_IDLE);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      run_xfer("post_rst", 16'h5A5A, 4'd15, 1'b0, 1'b0, 1'b0, 16'hC0DE, 1'b0);

      for (int i = 0; i < 3; i++) begin
         run_xfer("rand", 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                  1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_mstr_param.md
Name: spi_mstr_param

Overview:
Parametrised successor to the fixed 16-bit mode-0 SPI master. It is used by the sensor/inertial front-end and by any new peripherals.
- Run-time SPI mode (CPOL/CPHA) and transfer length up to DATA_W bits.
- Programmable SCLK divider.
- NUM_SS one-hot active-low slave selects.
- Configurable setup and hold porches around SCLK activity.
- Controlled by a single-cycle wrt pulse; completion reported by a sticky done.

Parameters:
DATA_W, 16, maximum bits per transaction (4..32).
HALF_DIV, 16, clk cycles per SCLK half period (even, >=2).
NUM_SS, 2, number of slave-select outputs (1..8).
SS_W, $clog2(NUM_SS) (min 1), width of ss_sel.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wrt  in  1  one-cycle start pulse; ignored while done=0
cmd  in  DATA_W  transmit word, right-aligned; the low len+1 bits are sent MSB first
len  in  $clog2(DATA_W)  bits-1 of the transfer (15 -> 16 bits)
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
ss_sel  in  SS_W  selects which SS_n bit goes low
SS_n  out  NUM_SS  active-low slave selects
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  1  serial data in
done  out  1  high when idle/complete; stays high until the next accepted wrt
rd_data  out  DATA_W  received word, right-aligned, upper bits zero

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: SS_n all 1, SCLK=0, done=1, rd_data=0, MOSI=0, state=IDLE, latched cpol/cpha/len/sel=0.
- Accept: on wrt&&done, cmd/len/cpol/cpha/ss_sel are latched.
  - Next cycle: done=0, selected SS_n=0, state FRONT.
  - ss_sel>=NUM_SS: transfer runs with every SS_n held high.
- States: IDLE -> FRONT -> SHIFT -> BACK -> IDLE.
- FRONT:
  - Lasts HALF_DIV cycles with SCLK=cpol.
  - CPHA=0: MOSI already shows bit len.
- SHIFT:
  - Produces N=len+1 SCLK periods.
  - Each half period is HALF_DIV cycles; the first edge is a leading edge.
  - Sample edge (leading if cpha=0, trailing if cpha=1): MISO is captured.
  - Opposite edge: MOSI advances to the next bit.
  - CPHA=1: the first leading edge presents bit len.
  - Exactly 2N SCLK edges occur.
- BACK:
  - Lasts HALF_DIV cycles with SCLK=cpol.
  - At exit: SS_n all 1, done=1, rd_data loaded with the N received bits (first received bit at position len).
- Latency: done rises exactly (2N+2)*HALF_DIV+1 cycles after the accepting wrt edge.
- MOSI outside a transaction: drives 0.
- rd_data: holds its value until the next completion; it is never partially updated.
- Collisions:
  - wrt while done=0 is ignored; no queueing.
  - wrt coincident with the completing cycle is ignored (done not yet 1).
- Reset mid-transfer: the next cycle shows reset values. There are no SCLK glitches beyond the immediate return to 0.
- Counters: half-period counter width $clog2(HALF_DIV); bit counter width $clog2(DATA_W)+1. Neither wraps in a legal transaction.

Optional Feature:
SPI_MOSI_TRISTATE_EN
- Defined: MOSI=1'bz whenever every SS_n is high (shared-bus mode).
- Undefined: MOSI drives 0 when idle, as stated above.
- Timing is identical in both builds.

Decomposition:
- Package spi_pkg:
  - state enum spi_state_t {IDLE,FRONT,SHIFT,BACK}
  - typedef spi_mode_t {cpol,cpha}
  - localparam MIN_HALF_DIV=2
- Sub-module spi_sclk_gen:
  - Half-period counter plus SCLK toggle.
  - Outputs lead_edge/trail_edge strobes one cycle wide.
  - Enabled and reset by the FSM.

Test Plan:
1. Mode 0: DATA_W=16, HALF_DIV=4, len=15, cmd=16'hA5C3, slave echoes 16'h3C5A -> MOSI bits match MSB first; rd_data=16'h3C5A; done high at 137 cycles.
2. Mode 3 (cpol=1, cpha=1), len=7, cmd=16'h00F0, slave returns 8'h81 -> SCLK idles 1; exactly 16 edges; rd_data=16'h0081.
3. Mode 1 vs mode 2, ss_sel=1, NUM_SS=2 -> SS_n=2'b01 during the transfer, 2'b11 otherwise; sampling on the correct edge checked against the bus model.
4. wrt pulsed mid-transfer plus a wrt on the completion cycle -> both ignored; one transaction only; done low for exactly 137 cycles.
5. rst asserted at bit 5 -> next cycle SS_n=all 1, SCLK=0, done=1, rd_data unchanged at 0; a following transfer completes normally.
6. SPI_MOSI_TRISTATE_EN build -> MOSI=z when idle, driven during FRONT/SHIFT/BACK; rd_data identical to the non-tristate build.
